// File: rtl/data_ram_responder_if.sv
// Data-memory bus between the MEM stage (master) and the RAM responder (slave).
interface data_ram_responder_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall_req;
  logic        err;

  modport master (output ce, we, addr, sel, wdata, input rdata, stall_req, err);
  modport slave  (input ce, we, addr, sel, wdata, output rdata, stall_req, err);
endinterface

// File: rtl/data_ram_responder.sv
// Word RAM responder for the MEM stage: zero-stall byte-lane stores, two-stall loads.
// Byte lanes are big-endian: sel[3] covers bits 31:24 at byte offset 0.
module data_ram_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input logic           clk,
  input logic           rst,
  data_ram_responder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  reject;
  logic                  st_ok;
  logic                  ld_ok;
  logic                  unused_lsb;

  // Byte offset within the word is carried by sel, not by the low address bits.
  assign unused_lsb = ^bus.addr[1:0];

  assign idx    = bus.addr[ADDR_WIDTH+1:2];
  assign reject = (bus.addr[31:ADDR_WIDTH+2] != '0) || (bus.sel == 4'b0000);
  assign st_ok  = (state == IDLE) && bus.ce && bus.we && !reject;
  assign ld_ok  = (state == IDLE) && bus.ce && !bus.we && !reject;

  assign bus.stall_req = ld_ok || (state == READ);
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

  // Array has no reset; a reset in the same cycle as a store blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && st_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sel[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_idx  <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && bus.ce && reject;
      case (state)
        IDLE: begin
          if (ld_ok) begin
            rd_idx <= idx;
            state  <= READ;
          end
        end
        READ: begin
          rdata_q <= mem[rd_idx];
          state   <= HOLD;
        end
        // Pipeline captures rdata this cycle; the still-presented load is not reissued.
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized self-checking bench for data_ram_responder against a word-array reference model.
module tb_data_ram_responder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [31:0] model [int];

  data_ram_responder_if bus();
  data_ram_responder #(.ADDR_WIDTH(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.sel = 4'h0; bus.wdata = 32'h0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] addr);
    int k;
    k = int'(addr[11:2]);
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  // One-cycle store; model updated only for accepted, non-reset requests.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] sel,
                          output logic st);
    int k;
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = addr; bus.sel = sel; bus.wdata = d;
    #1;
    st = bus.stall_req;
    if (addr[31:12] == 20'h0 && sel != 4'h0 && rst !== 1'b1) begin
      k = int'(addr[11:2]);
      model[k] = merge(model.exists(k) ? model[k] : 32'h0, d, sel);
    end
    tick;
    idle_bus;
  endtask

  // Load held while stalled; returns stall-cycle count (bounded) and the HOLD-cycle data.
  task automatic do_load(input logic [31:0] addr, output logic [31:0] d, output int stalls,
                         output int start);
    start = cyc;
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = addr; bus.sel = 4'hF; bus.wdata = $urandom;
    #1;
    stalls = 0;
    while (bus.stall_req === 1'b1 && stalls < 8) begin
      stalls++;
      tick;
    end
    d = bus.rdata;
    tick;
    idle_bus;
  endtask

  task automatic test_reset;
    idle_bus;
    rst = 1'b1;
    tick; tick;
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0); end
    checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_byte_store;
    logic st; logic [31:0] d; int n, s0;
    do_store(32'h0, 32'h11111111, 4'b1111, st);
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL byte_store_stall got=%b exp=0", st); end
    do_store(32'h1, 32'hABABABAB, 4'b0100, st);
    do_load(32'h0, d, n, s0);
    checks++; if (d !== expect_word(32'h0)) begin failures++; $display("FAIL byte_load got=%h exp=%h", d, expect_word(32'h0)); end
    checks++; if (n !== 2) begin failures++; $display("FAIL byte_load_stalls got=%0d exp=2", n); end
  endtask

  task automatic test_half_word;
    logic st; logic [31:0] d; int n, s0;
    do_store(32'h100, 32'h0, 4'b1111, st);
    do_store(32'h102, 32'hCAFECAFE, 4'b0011, st);
    do_load(32'h100, d, n, s0);
    checks++; if (d !== expect_word(32'h100)) begin failures++; $display("FAIL half_load got=%h exp=%h", d, expect_word(32'h100)); end
    do_store(32'h0, 32'hDEADBEEF, 4'b1111, st);
    do_load(32'h0, d, n, s0);
    checks++; if (d !== expect_word(32'h0)) begin failures++; $display("FAIL word_after_store got=%h exp=%h", d, expect_word(32'h0)); end
  endtask

  task automatic test_reset_mid_load;
    logic [31:0] d; int n, s0;
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = 32'h0; bus.sel = 4'hF;
    tick;
    checks++; if (bus.stall_req !== 1'b1) begin failures++; $display("FAIL mid_load_read_stall got=%b exp=1", bus.stall_req); end
    rst = 1'b1;
    idle_bus;
    tick;
    rst = 1'b0;
    checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL mid_load_stall got=%b exp=0", bus.stall_req); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL mid_load_rdata got=%h exp=%h", bus.rdata, 32'h0); end
    tick;
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL mid_load_late_rdata got=%h exp=%h", bus.rdata, 32'h0); end
    do_load(32'h0, d, n, s0);
    checks++; if (d !== expect_word(32'h0)) begin failures++; $display("FAIL mid_load_reload got=%h exp=%h", d, expect_word(32'h0)); end
    checks++; if (n !== 2) begin failures++; $display("FAIL mid_load_reload_stalls got=%0d exp=2", n); end
  endtask

  task automatic test_ce_drop;
    logic st;
    do_store(32'h4, $urandom, 4'hF, st);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = 32'h4; bus.sel = 4'hF;
    tick;
    idle_bus;
    tick;
    checks++; if (bus.rdata !== expect_word(32'h4)) begin failures++; $display("FAIL ce_drop_rdata got=%h exp=%h", bus.rdata, expect_word(32'h4)); end
    checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL ce_drop_hold_stall got=%b exp=0", bus.stall_req); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic st; logic [31:0] d; int n, s0, prev;
    do_store(32'h8, $urandom, 4'hF, st);
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      do_load(32'(i * 4), d, n, s0);
      checks++; if (d !== expect_word(32'(i * 4))) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, d, expect_word(32'(i * 4))); end
      checks++; if (n !== 2) begin failures++; $display("FAIL b2b_stalls[%0d] got=%0d exp=2", i, n); end
      if (prev >= 0) begin
        checks++; if (s0 - prev !== 3) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=3", i, s0 - prev); end
      end
      prev = s0;
    end
  endtask

  task automatic test_rejects;
    logic [31:0] d, prev; int n, s0;
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h00001000; bus.sel = 4'hF; bus.wdata = 32'h55555555;
    #1;
    checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL oor_stall got=%b exp=0", bus.stall_req); end
    tick;
    idle_bus;
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", bus.err); end
    tick;
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL oor_err_pulse got=%b exp=0", bus.err); end
    do_load(32'h0, d, n, s0);
    checks++; if (d !== expect_word(32'h0)) begin failures++; $display("FAIL oor_ram0 got=%h exp=%h", d, expect_word(32'h0)); end
    prev = d;
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = 32'h4; bus.sel = 4'h0;
    #1;
    checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL nosel_stall got=%b exp=0", bus.stall_req); end
    tick;
    idle_bus;
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL nosel_err got=%b exp=1", bus.err); end
    tick; tick;
    checks++; if (bus.rdata !== prev) begin failures++; $display("FAIL nosel_rdata got=%h exp=%h", bus.rdata, prev); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL nosel_err_pulse got=%b exp=0", bus.err); end
  endtask

  task automatic test_idle;
    logic [31:0] d; int n, s0;
    for (int i = 0; i < 20; i++) begin
      bus.ce = 1'b0; bus.we = 1'($urandom); bus.addr = $urandom_range(0, 63);
      bus.sel = 4'($urandom); bus.wdata = $urandom;
      #1;
      checks++; if (bus.stall_req !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL idle[%0d] stall=%b err=%b exp=0,0", i, bus.stall_req, bus.err); end
      tick;
    end
    idle_bus;
    for (int w = 0; w < 3; w++) begin
      do_load(32'(w * 4), d, n, s0);
      checks++; if (d !== expect_word(32'(w * 4))) begin failures++; $display("FAIL idle_ram[%0d] got=%h exp=%h", w, d, expect_word(32'(w * 4))); end
    end
  endtask

  task automatic test_random;
    logic st; logic [31:0] d, a; int n, s0;
    for (int w = 0; w < 16; w++) do_store(32'(w * 4), $urandom, 4'hF, st);
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) a[31:12] = 20'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) begin
        do_store(a, $urandom, 4'($urandom_range(1, 15)), st);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL rand_store_stall[%0d] got=%b exp=0", i, st); end
      end else if (a[31:12] == 20'h0) begin
        do_load(a, d, n, s0);
        checks++; if (d !== expect_word(a)) begin failures++; $display("FAIL rand_load[%0d] addr=%h got=%h exp=%h", i, a, d, expect_word(a)); end
        checks++; if (n !== 2) begin failures++; $display("FAIL rand_load_stalls[%0d] got=%0d exp=2", i, n); end
      end
    end
  endtask

  task automatic test_reset_store;
    logic st; logic [31:0] d; int n, s0;
    rst = 1'b1;
    do_store(32'h0, ~expect_word(32'h0), 4'hF, st);
    rst = 1'b0;
    tick;
    do_load(32'h0, d, n, s0);
    checks++; if (d !== expect_word(32'h0)) begin failures++; $display("FAIL reset_store_suppress got=%h exp=%h", d, expect_word(32'h0)); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset;
    test_byte_store;
    test_half_word;
    test_reset_mid_load;
    test_ce_drop;
    test_back_to_back;
    test_rejects;
    test_idle;
    test_random;
    test_reset_store;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
